// File: rtl/vcxp_capture_writer.sv
// Crops the decoder byte stream to a window and writes it to SRAM; CAP_FIELD_SEL_EN restricts capture to field 0.
// Latency: byte registered at edge n drives SRAM at edge n+2; no backpressure, the stream is free-running.
module vcxp_capture_writer #(
  parameter int X_START    = 0,
  parameter int X_LEN      = 1440,
  parameter int Y_START    = 0,
  parameter int Y_LEN      = 288,
  parameter int LINE_PITCH = 1440
) (
  input  logic        llc,
  input  logic        rst_n,
  input  logic        HREF,
  input  logic        VREF,
  input  logic [7:0]  YUV,
  input  logic        FIELD,
  input  logic        start,
  input  logic        abort,
  input  logic [18:0] base_adr,
  output logic [18:0] sramAdr,
  output logic [7:0]  sramDout,
  output logic        sramwe_n,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        short_frm
);

  localparam logic [11:0] X_LO  = 12'(X_START);
  localparam logic [11:0] X_N   = 12'(X_LEN);
  localparam logic [10:0] Y_LO  = 11'(Y_START);
  localparam logic [10:0] Y_N   = 11'(Y_LEN);
  localparam logic [10:0] Y_HI  = 11'(Y_START + Y_LEN);
  localparam logic [18:0] PITCH = 19'(LINE_PITCH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        href1_q, vref1_q, field1_q, href_p_q, vref_p_q;
  logic [7:0]  yuv1_q;
  logic [18:0] base_q, base_d, line_base_q, line_base_d;
  logic [10:0] xcnt_q, xcnt_d;
  logic [9:0]  ycnt_q, ycnt_d;
  logic        pend_we_q, pend_we_d;
  logic [18:0] pend_adr_q, pend_adr_d, adr_q, adr_d;
  logic [7:0]  pend_dat_q, pend_dat_d, dout_q, dout_d;
  logic        we_n_q, we_n_d, ovf_q, ovf_d, short_q, short_d;

  logic        href_fall, vref_rise, vref_fall, capture_go, in_x, in_y;
  logic [11:0] xoff;
  logic [10:0] yoff;
  logic [20:0] adr_sum;
  logic [19:0] lb_sum;

  assign href_fall = href_p_q & ~href1_q;
  assign vref_rise = vref1_q & ~vref_p_q;
  assign vref_fall = vref_p_q & ~vref1_q;

`ifdef CAP_FIELD_SEL_EN
  assign capture_go = vref_rise & ~field1_q;
`else
  logic unused_field;
  assign unused_field = field1_q;
  assign capture_go   = vref_rise;
`endif

  // Offsets wrap to large values below the window start, so one compare covers both bounds.
  assign xoff    = {1'b0, xcnt_q} - X_LO;
  assign yoff    = {1'b0, ycnt_q} - Y_LO;
  assign in_x    = xoff < X_N;
  assign in_y    = yoff < Y_N;
  assign adr_sum = 21'(base_q) + 21'(line_base_q) + 21'(xoff[10:0]);
  assign lb_sum  = 20'(line_base_q) + 20'(PITCH);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    line_base_d = line_base_q;
    xcnt_d      = xcnt_q;
    ycnt_d      = ycnt_q;
    pend_we_d   = 1'b0;
    pend_adr_d  = pend_adr_q;
    pend_dat_d  = pend_dat_q;
    adr_d       = pend_we_q ? pend_adr_q : adr_q;
    dout_d      = pend_we_q ? pend_dat_q : dout_q;
    we_n_d      = ~pend_we_q;
    ovf_d       = ovf_q;
    short_d     = short_q;
    if (abort) begin
      state_d = S_IDLE;
      adr_d   = adr_q;
      dout_d  = dout_q;
      we_n_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_WAIT;
            base_d  = base_adr;
            ovf_d   = 1'b0;
            short_d = 1'b0;
          end
        end
        S_WAIT: begin
          if (capture_go) begin
            state_d     = S_CAPT;
            xcnt_d      = '0;
            ycnt_d      = '0;
            line_base_d = '0;
          end
        end
        S_CAPT: begin
          if (vref1_q && href1_q) begin
            if (xcnt_q != '1) xcnt_d = xcnt_q + 11'd1;
            if (in_x && in_y) begin
              pend_we_d  = 1'b1;
              pend_adr_d = adr_sum[18:0];
              pend_dat_d = yuv1_q;
              if (adr_sum[20:19] != 2'b00) ovf_d = 1'b1;
            end
          end
          if (href_fall && vref1_q) begin
            xcnt_d = '0;
            ycnt_d = ycnt_q + 10'd1;
            // Short lines still advance by the full pitch so rows stay aligned.
            if (in_y) begin
              line_base_d = lb_sum[18:0];
              if (lb_sum[19]) ovf_d = 1'b1;
            end
            if (({1'b0, ycnt_q} + 11'd1) == Y_HI) state_d = S_DONE;
          end else if (vref_fall) begin
            state_d = S_DONE;
            short_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge llc or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      href1_q     <= 1'b0;
      vref1_q     <= 1'b0;
      field1_q    <= 1'b0;
      yuv1_q      <= '0;
      href_p_q    <= 1'b0;
      vref_p_q    <= 1'b0;
      base_q      <= '0;
      line_base_q <= '0;
      xcnt_q      <= '0;
      ycnt_q      <= '0;
      pend_we_q   <= 1'b0;
      pend_adr_q  <= '0;
      pend_dat_q  <= '0;
      adr_q       <= '0;
      dout_q      <= '0;
      we_n_q      <= 1'b1;
      ovf_q       <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      href1_q     <= HREF;
      vref1_q     <= VREF;
      field1_q    <= FIELD;
      yuv1_q      <= YUV;
      href_p_q    <= href1_q;
      vref_p_q    <= vref1_q;
      base_q      <= base_d;
      line_base_q <= line_base_d;
      xcnt_q      <= xcnt_d;
      ycnt_q      <= ycnt_d;
      pend_we_q   <= pend_we_d;
      pend_adr_q  <= pend_adr_d;
      pend_dat_q  <= pend_dat_d;
      adr_q       <= adr_d;
      dout_q      <= dout_d;
      we_n_q      <= we_n_d;
      ovf_q       <= ovf_d;
      short_q     <= short_d;
    end
  end

  assign sramAdr   = adr_q;
  assign sramDout  = dout_q;
  assign sramwe_n  = we_n_q;
  assign busy      = (state_q == S_WAIT) || (state_q == S_CAPT);
  assign done      = (state_q == S_DONE);
  assign ovf       = ovf_q;
  assign short_frm = short_q;

endmodule

// File: tb/tb_vcxp_capture_writer.sv
// Scoreboard bench for vcxp_capture_writer: stimulus pushes expected SRAM writes, a monitor pops them.
module tb_vcxp_capture_writer;

  logic        llc = 1'b0;
  logic        rst_n, HREF, VREF, FIELD, start, abort;
  logic [7:0]  YUV;
  logic [18:0] base_adr;
  logic [18:0] sramAdr;
  logic [7:0]  sramDout;
  logic        sramwe_n, busy, done, ovf, short_frm;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  logic [26:0] sb[$];

  vcxp_capture_writer #(
    .X_START(0), .X_LEN(4), .Y_START(0), .Y_LEN(2), .LINE_PITCH(1440)
  ) dut (
    .llc(llc), .rst_n(rst_n), .HREF(HREF), .VREF(VREF), .YUV(YUV), .FIELD(FIELD),
    .start(start), .abort(abort), .base_adr(base_adr),
    .sramAdr(sramAdr), .sramDout(sramDout), .sramwe_n(sramwe_n),
    .busy(busy), .done(done), .ovf(ovf), .short_frm(short_frm)
  );

  always #5 llc = ~llc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge llc);
      if (rst_n === 1'b1 && sramwe_n === 1'b0) begin
        wr_cnt++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h, expected no write", sramAdr, sramDout);
        end else begin
          check("sram_write", {5'd0, sramAdr, sramDout}, {5'd0, sb.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge llc);
    #1;
  endtask

  task automatic pulse_start(input logic [18:0] a);
    base_adr = a;
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
  endtask

  task automatic push(input logic [18:0] a, input logic [7:0] d);
    sb.push_back({a, d});
  endtask

  task automatic send_line(input int n, input logic [7:0] b0);
    HREF = 1'b1;
    for (int i = 0; i < n; i++) begin
      YUV = b0 + 8'(i);
      cyc(1);
    end
    HREF = 1'b0;
    YUV  = 8'h00;
    cyc(4);
  endtask

  task automatic frame_begin();
    VREF = 1'b1;
    cyc(3);
  endtask

  task automatic frame_end();
    VREF = 1'b0;
    cyc(4);
  endtask

  int w0;
  logic [18:0] a;

  initial begin
    rst_n = 1'b0; HREF = 1'b0; VREF = 1'b0; FIELD = 1'b0; start = 1'b0; abort = 1'b0;
    YUV = 8'h00; base_adr = '0;
    cyc(3);
    check("rst_we_n", {31'd0, sramwe_n}, 32'd1);
    check("rst_adr", {13'd0, sramAdr}, 32'd0);
    check("rst_dout", {24'd0, sramDout}, 32'd0);
    check("rst_status", {28'd0, busy, done, ovf, short_frm}, 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Two 6-byte lines cropped to 4 bytes each, pitch 1440.
    w0 = wr_cnt;
    pulse_start(19'd0);
    cyc(1);
    check("wait_busy", {31'd0, busy}, 32'd1);
    frame_begin();
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 4; i++) push(19'(l * 1440 + i), 8'h10 + 8'(i));
      send_line(6, 8'h10);
    end
    frame_end();
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_flags", {30'd0, ovf, short_frm}, 32'd0);
    check("t1_writes", 32'(wr_cnt - w0), 32'd8);

    // Address wrap past 19'h7FFFF.
    w0 = wr_cnt;
    pulse_start(19'h7FFFE);
    frame_begin();
    push(19'h7FFFE, 8'h20); push(19'h7FFFF, 8'h21); push(19'h00000, 8'h22); push(19'h00001, 8'h23);
    send_line(4, 8'h20);
    push(19'h0059E, 8'h20); push(19'h0059F, 8'h21); push(19'h005A0, 8'h22); push(19'h005A1, 8'h23);
    send_line(4, 8'h20);
    frame_end();
    check("t2_ovf", {31'd0, ovf}, 32'd1);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_writes", 32'(wr_cnt - w0), 32'd8);

    // Short frame; a second start while waiting must not relatch the base.
    w0 = wr_cnt;
    pulse_start(19'h00100);
    cyc(1);
    pulse_start(19'h07000);
    frame_begin();
    for (int i = 0; i < 4; i++) push(19'h00100 + 19'(i), 8'h30 + 8'(i));
    send_line(4, 8'h30);
    frame_end();
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_short", {31'd0, short_frm}, 32'd1);
    check("t3_ovf_cleared", {31'd0, ovf}, 32'd0);
    check("t3_writes", 32'(wr_cnt - w0), 32'd4);

    // Abort to IDLE, then simultaneous start+abort must stay idle.
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(1);
    check("t4_abort_done", {31'd0, done}, 32'd0);
    base_adr = 19'h00400;
    start = 1'b1; abort = 1'b1;
    cyc(1);
    start = 1'b0; abort = 1'b0;
    cyc(1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    w0 = wr_cnt;
    frame_begin();
    send_line(4, 8'h70);
    send_line(4, 8'h70);
    frame_end();
    check("t4_writes", 32'(wr_cnt - w0), 32'd0);
    check("t4_done", {31'd0, done}, 32'd0);

    // Field-1 frame followed by a field-0 frame.
    w0 = wr_cnt;
    pulse_start(19'h00300);
    FIELD = 1'b1;
    frame_begin();
`ifndef CAP_FIELD_SEL_EN
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 4; i++) push(19'h00300 + 19'(l * 1440 + i), 8'h40 + 8'(i));
`endif
    send_line(4, 8'h40);
    send_line(4, 8'h40);
    frame_end();
    FIELD = 1'b0;
    frame_begin();
`ifdef CAP_FIELD_SEL_EN
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 4; i++) push(19'h00300 + 19'(l * 1440 + i), 8'h50 + 8'(i));
`endif
    send_line(4, 8'h50);
    send_line(4, 8'h50);
    frame_end();
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_writes", 32'(wr_cnt - w0), 32'd8);

    // Reset while capturing, between lines.
    pulse_start(19'h00200);
    frame_begin();
    for (int i = 0; i < 4; i++) push(19'h00200 + 19'(i), 8'h60 + 8'(i));
    send_line(4, 8'h60);
    check("t6_busy_pre", {31'd0, busy}, 32'd1);
    a = sramAdr;
    check("t6_adr_pre", {13'd0, a}, 32'h203);
    rst_n = 1'b0;
    #1;
    check("t6_rst_we_n", {31'd0, sramwe_n}, 32'd1);
    check("t6_rst_adr", {13'd0, sramAdr}, 32'd0);
    check("t6_rst_dout", {24'd0, sramDout}, 32'd0);
    check("t6_rst_status", {28'd0, busy, done, ovf, short_frm}, 32'd0);
    cyc(1);
    rst_n = 1'b1;
    w0 = wr_cnt;
    send_line(4, 8'h68);
    frame_end();
    check("t6_idle_writes", 32'(wr_cnt - w0), 32'd0);
    check("t6_busy_post", {31'd0, busy}, 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
